// File: rtl/aca_result_stage.sv
// ---------------------------------------------------------------------------
// aca_result_stage
//
// Result stage behind an almost-correct adder (ACA) window array. It accepts
// the operands together with the speculative sum and carry-out from the
// window adders. A conservative detector flags any operand pair whose
// propagate vector holds a run of >= window ones, because such a chain can
// carry further than one window adder looks back.
//   - Unflagged: the speculative result is passed through, visible one cycle
//     after acceptance.
//   - Flagged: the exact sum is rebuilt by a chunked ripple, chunk bits per
//     cycle. The result is visible 1 + width/chunk cycles after acceptance.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk_i edge where valid and ready are both
//   high. Once out_valid_o is high, it stays high, and result_o/carry_o/error_o
//   stay stable, until that transfer happens. in_ready_o is high only in IDLE.
//   The stage does not accept new input in the cycle in which a result leaves.
//
// Parameters:
//   width  - operand/result width
//   window - carry-lookback length of each window adder (2 <= window <= width)
//   chunk  - bits corrected per cycle (width % chunk == 0)
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o upstream handshake
//   operand1_i/operand2_i addends A and B
//   spec_sum_i            speculative sum from the window adders
//   spec_carry_i          speculative carry-out of the MSB window
//   out_valid_o/out_ready_i downstream handshake
//   result_o, carry_o     final sum and carry-out (bit width of the sum)
//   error_o               detector flagged the transaction; result corrected
//
// Optional build macro ACA_ERR_COUNT_EN adds two ports:
//   flag_count_o[15:0]     transactions that entered correction (saturating)
//   mismatch_count_o[15:0] corrections that changed the speculative
//                          {carry,sum}, i.e. true errors (saturating)
//
// The FSM state is held in state_q (type state_t) so checkers can bind to it.
// ---------------------------------------------------------------------------
module aca_result_stage #(
  parameter int width  = 16,
  parameter int window = 6,
  parameter int chunk  = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [width-1:0] operand1_i,
  input  logic [width-1:0] operand2_i,
  input  logic [width-1:0] spec_sum_i,
  input  logic             spec_carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [width-1:0] result_o,
  output logic             carry_o,
  output logic             error_o
`ifdef ACA_ERR_COUNT_EN
  ,
  output logic [15:0]      flag_count_o,
  output logic [15:0]      mismatch_count_o
`endif
);

  localparam int nchunks = width / chunk;
  localparam int idx_w   = (nchunks > 1) ? $clog2(nchunks) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(nchunks - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CORRECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             state_q, state_d;

  logic [width-1:0]   a_q, b_q;          // shift right by chunk per correction cycle
  logic [width-1:0]   result_q;
  logic               carry_q;
  logic               error_q;
  logic [idx_w-1:0]   idx_q;
  logic               run_carry_q;

  logic [width-1:0]   p;
  logic               flag;
  logic               accept;
  logic               last_slice;
  logic [chunk:0]     slice_sum;
  logic [width+chunk-1:0] shift_tmp;
  logic [width-1:0]   corr_result;

  // -------------------------------------------------------------------------
  // Detector: any run of >= window ones in the propagate vector.
  // -------------------------------------------------------------------------
  always_comb begin
    p    = operand1_i ^ operand2_i;
    flag = 1'b0;
    for (int i = 0; i <= width - window; i++) begin
      if (&p[i +: window]) flag = 1'b1;
    end
  end

  assign accept     = in_valid_i & in_ready_o;
  assign last_slice = (idx_q == last_idx);

  // -------------------------------------------------------------------------
  // Correction datapath. The operands are shifted right so the current slice
  // is always in the low chunk bits. Each new sum slice enters result_q from
  // the top. After nchunks shifts the result is complete and in bit order.
  // -------------------------------------------------------------------------
  always_comb begin
    slice_sum   = {1'b0, a_q[chunk-1:0]} + {1'b0, b_q[chunk-1:0]}
                + {{chunk{1'b0}}, run_carry_q};
    shift_tmp   = {slice_sum[chunk-1:0], result_q};
    corr_result = shift_tmp[width+chunk-1:chunk];
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = flag ? ST_CORRECT : ST_DONE;
      end
      ST_CORRECT: begin
        if (last_slice) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign out_valid_o = (state_q == ST_DONE);

  // -------------------------------------------------------------------------
  // Datapath registers. Outputs keep their value outside of an update.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      error_q     <= 1'b0;
      idx_q       <= '0;
      run_carry_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            a_q         <= operand1_i;
            b_q         <= operand2_i;
            // A flagged transaction shifts this value out during correction.
            result_q    <= spec_sum_i;
            carry_q     <= spec_carry_i;
            error_q     <= flag;
            idx_q       <= '0;
            run_carry_q <= 1'b0;
          end
        end
        ST_CORRECT: begin
          a_q         <= a_q >> chunk;
          b_q         <= b_q >> chunk;
          result_q    <= corr_result;
          run_carry_q <= slice_sum[chunk];
          idx_q       <= idx_q + 1'b1;
          if (last_slice) carry_q <= slice_sum[chunk];
        end
        default: ;
      endcase
    end
  end

  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign error_o  = error_q;

`ifdef ACA_ERR_COUNT_EN
  logic [width-1:0] spec_sum_q;
  logic             spec_carry_q;
  logic [15:0]      flag_cnt_q;
  logic [15:0]      mism_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      spec_sum_q   <= '0;
      spec_carry_q <= 1'b0;
      flag_cnt_q   <= '0;
      mism_cnt_q   <= '0;
    end else begin
      if (accept) begin
        spec_sum_q   <= spec_sum_i;
        spec_carry_q <= spec_carry_i;
        if (flag && flag_cnt_q != 16'hFFFF) flag_cnt_q <= flag_cnt_q + 16'd1;
      end
      // A false alarm leaves {carry,sum} unchanged and is not counted.
      if (state_q == ST_CORRECT && last_slice &&
          {slice_sum[chunk], corr_result} != {spec_carry_q, spec_sum_q} &&
          mism_cnt_q != 16'hFFFF) begin
        mism_cnt_q <= mism_cnt_q + 16'd1;
      end
    end
  end

  assign flag_count_o     = flag_cnt_q;
  assign mismatch_count_o = mism_cnt_q;
`endif

endmodule

// File: tb/tb_aca_result_stage.sv
module tb_aca_result_stage;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1, op2, spec_sum;
  logic         spec_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         error;
`ifdef ACA_ERR_COUNT_EN
  logic [15:0]  flag_count, mismatch_count;
  int           flag_m = 0;
  int           mism_m = 0;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // {error, carry, result}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a, b, ss;
    logic         sc;
    int           hold;
    logic [W-1:0] er;
    logic         ec;
    logic         ee;
  } vec_t;

  vec_t vecs[9];

  aca_result_stage dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .operand1_i      (op1),
    .operand2_i      (op2),
    .spec_sum_i      (spec_sum),
    .spec_carry_i    (spec_carry),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .result_o        (result),
    .carry_o         (carry),
    .error_o         (error)
`ifdef ACA_ERR_COUNT_EN
    ,
    .flag_count_o    (flag_count),
    .mismatch_count_o(mismatch_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent model of the detector: longest run of ones in the propagate vector.
  function automatic logic run_flag(input logic [W-1:0] p);
    int run;
    run = 0;
    for (int i = 0; i < W; i++) begin
      run = p[i] ? run + 1 : 0;
      if (run >= 6) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ss, input logic sc, input int hold,
                        input logic [W-1:0] er, input logic ec, input logic ee,
                        input string name);
    int n;
    logic [W+1:0] e;
    exp_q.push_back({ee, ec, er});
    @(negedge clk);
    chk({name, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    op1        = a;
    op2        = b;
    spec_sum   = ss;
    spec_carry = sc;
    @(posedge clk);
    @(negedge clk);
    // Inputs change after acceptance; the stage must ignore them.
    in_valid   = 1'b0;
    op1        = 16'($urandom_range(0, 65535));
    op2        = 16'($urandom_range(0, 65535));
    spec_sum   = 16'($urandom_range(0, 65535));
    spec_carry = 1'($urandom_range(0, 1));
    n = 1;
    while (!out_valid && n < 50) begin
      chk({name, "/in_ready_busy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk({name, "/latency"}, 32'(n), ee ? 32'd5 : 32'd1);
    for (int h = 0; h < hold; h++) begin
      chk({name, "/hold_out"}, {12'd0, in_ready, out_valid, error, carry, result},
          {12'd0, 1'b0, 1'b1, ee, ec, er});
      @(negedge clk);
    end
    e = exp_q.pop_front();
    chk({name, "/valid"},  32'(out_valid), 32'd1);
    chk({name, "/result"}, 32'(result), 32'(e[W-1:0]));
    chk({name, "/carry"},  32'(carry),  32'(e[W]));
    chk({name, "/error"},  32'(error),  32'(e[W+1]));
`ifdef ACA_ERR_COUNT_EN
    if (ee) flag_m++;
    if (ee && {ec, er} != {sc, ss}) mism_m++;
    chk({name, "/flag_count"},     32'(flag_count),     32'(flag_m));
    chk({name, "/mismatch_count"}, 32'(mismatch_count), 32'(mism_m));
`endif
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "/valid_drop"},  32'(out_valid), 32'd0);
    chk({name, "/ready_back"},  32'(in_ready),  32'd1);
    chk({name, "/result_keep"}, 32'(result),    32'(e[W-1:0]));
  endtask

  initial begin
    logic [W-1:0] a, b, ss, er;
    logic         sc, f;
    logic [W:0]   sum;

    //        a         b         ss        sc  hold er        ec  ee
    vecs[0] = '{16'h0003, 16'h0005, 16'h0008, 0, 0, 16'h0008, 0, 1};
    vecs[0].ee = 1'b0;
    vecs[1] = '{16'h00FF, 16'h0001, 16'h0080, 0, 0, 16'h0100, 0, 1};
    vecs[2] = '{16'hFFFF, 16'h0001, 16'h0000, 0, 0, 16'h0000, 1, 1};
    vecs[3] = '{16'h00FC, 16'h0000, 16'h00FC, 0, 0, 16'h00FC, 0, 1};
    vecs[4] = '{16'h0012, 16'h0021, 16'h0033, 0, 3, 16'h0033, 0, 0};
    vecs[5] = '{16'h8000, 16'h8000, 16'h1234, 1, 0, 16'h1234, 1, 0};
    vecs[6] = '{16'h003F, 16'h0000, 16'h0000, 0, 2, 16'h003F, 0, 1};
    vecs[7] = '{16'h001F, 16'h0000, 16'hAAAA, 0, 0, 16'hAAAA, 0, 0};
    vecs[8] = '{16'hF0F0, 16'h0FF0, 16'h0000, 0, 1, 16'h00E0, 1, 1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op1 = '0; op2 = '0; spec_sum = '0; spec_carry = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset/outputs", {12'd0, in_ready, out_valid, error, carry, result},
        {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].a, vecs[i].b, vecs[i].ss, vecs[i].sc, vecs[i].hold,
             vecs[i].er, vecs[i].ec, vecs[i].ee, $sformatf("vec%0d", i));
    end

    // random transactions, about half of them forced to contain a long run
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      if (i % 2 == 1) b = a ^ (16'($urandom_range(0, 65535)) | (16'h003F << $urandom_range(0, 10)));
      ss  = (i % 3 == 0) ? a + b : 16'($urandom_range(0, 65535));
      sc  = 1'($urandom_range(0, 1));
      f   = run_flag(a ^ b);
      sum = {1'b0, a} + {1'b0, b};
      er  = f ? sum[W-1:0] : ss;
      do_txn(a, b, ss, sc, $urandom_range(0, 2), er, f ? sum[W] : sc, f,
             $sformatf("rnd%0d", i));
    end

    // reset in the middle of a correction (idx == 2)
    @(negedge clk);
    in_valid = 1'b1; op1 = 16'h0FC3; op2 = 16'h0000; spec_sum = 16'h0FC3; spec_carry = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort/busy", {30'd0, in_ready, out_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort/valid", 32'(out_valid), 32'd0);
    chk("abort/result", 32'(result), 32'd0);
    chk("abort/carry_error", {30'd0, carry, error}, 32'd0);
`ifdef ACA_ERR_COUNT_EN
    flag_m = 0;
    mism_m = 0;
    chk("abort/counts", {flag_count, mismatch_count}, 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort/ready", 32'(in_ready), 32'd1);
    do_txn(16'h0001, 16'h0001, 16'h0002, 1'b0, 0, 16'h0002, 1'b0, 1'b0, "after_abort");

    chk("scoreboard/empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
